// File: rtl/alu_extender_flipflop32.sv
// Execute-stage arithmetic slice: 14-to-32-bit immediate extender, 4-bit-controlled ALU
// with zero/negative/positive flags, and an enable-gated result register with async clear.
module alu_extender_flipflop32 (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [13:0] imm_in,
   input  logic        ext_ctrl,
   input  logic        src_imm,
   input  logic [3:0]  alu_control,
   input  logic        en,
   input  logic        write_en,
   output logic [31:0] imm_out,
   output logic [31:0] y,
   output logic        zero,
   output logic        negative,
   output logic        positive,
   output logic [31:0] result_q
);

   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000,
      OP_SUB  = 4'b0001,
      OP_AND  = 4'b0010,
      OP_OR   = 4'b0011,
      OP_XOR  = 4'b0100,
      OP_NOR  = 4'b0101,
      OP_SLL  = 4'b0110,
      OP_SRL  = 4'b0111,
      OP_SRA  = 4'b1000,
      OP_SLT  = 4'b1001,
      OP_SLTU = 4'b1010,
      OP_PASS = 4'b1011
   } alu_op_t;

   alu_op_t     op;
   logic [31:0] opb;
   logic [4:0]  shamt;

   assign imm_out = ext_ctrl ? {{18{imm_in[13]}}, imm_in} : {18'b0, imm_in};
   assign opb     = src_imm ? imm_out : b;
   assign shamt   = opb[4:0];
   assign op      = alu_op_t'(alu_control);

   always_comb begin
      // NOTE: y gets a default before the case so no path leaves it unassigned (no latch).
      y = 32'h0;
      if (en) begin
         case (op)
            OP_ADD:  y = a + opb;
            OP_SUB:  y = a - opb;
            OP_AND:  y = a & opb;
            OP_OR:   y = a | opb;
            OP_XOR:  y = a ^ opb;
            OP_NOR:  y = ~(a | opb);
            OP_SLL:  y = a << shamt;
            OP_SRL:  y = a >> shamt;
            OP_SRA:  y = $signed(a) >>> shamt;
            OP_SLT:  y = {31'b0, $signed(a) < $signed(opb)};
            OP_SLTU: y = {31'b0, a < opb};
            OP_PASS: y = opb;
            default: y = 32'h0;
         endcase
      end
   end

   // Flags are gated by en: with en=0 y is forced to zero, yet zero must also read 0.
   assign zero     = en & (y == 32'h0);
   assign negative = en & y[31];
   assign positive = en & ~y[31] & (y != 32'h0);

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      if (reset)
         result_q <= 32'h0;
      else if (write_en)
         result_q <= y;
   end

endmodule

// File: tb/tb_alu_extender_flipflop32.sv
// Self-checking bench: table-driven combinational vectors, directed reset/hold sequences,
// and a random sweep, with result_q checked through a scoreboard queue.
module tb_alu_extender_flipflop32;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] a = '0, b = '0;
   logic [13:0] imm_in = '0;
   logic        ext_ctrl = 1'b0, src_imm = 1'b0, en = 1'b1, write_en = 1'b0;
   logic [3:0]  alu_control = '0;
   logic [31:0] imm_out, y, result_q;
   logic        zero, negative, positive;

   int checks = 0;
   int failures = 0;
   logic [31:0] sb[$];
   logic [31:0] last_q;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [13:0] imm;
      logic        ext;
      logic        src;
      logic [3:0]  op;
      logic        en;
      logic [31:0] exp_y;
      logic [2:0]  exp_f;   // {zero, negative, positive}
      logic [31:0] exp_imm;
   } vec_t;

   vec_t vecs[$];

   alu_extender_flipflop32 dut (
      .clk(clk), .reset(reset), .a(a), .b(b), .imm_in(imm_in),
      .ext_ctrl(ext_ctrl), .src_imm(src_imm), .alu_control(alu_control),
      .en(en), .write_en(write_en), .imm_out(imm_out), .y(y),
      .zero(zero), .negative(negative), .positive(positive), .result_q(result_q)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_sb(input string name);
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s: scoreboard empty, got %h expected none", name, result_q);
      end else begin
         check(name, result_q, sb.pop_front());
      end
   endtask

   function automatic logic [31:0] model_y(input logic [31:0] x, input logic [31:0] o,
                                           input logic [3:0] op, input logic e);
      logic [63:0] wide;
      logic [4:0]  sh;
      sh = o[4:0];
      if (!e) return 32'h0;
      case (op)
         4'h0: return x + o;
         4'h1: return x + ~o + 32'd1;
         4'h2: return x & o;
         4'h3: return x | o;
         4'h4: return x ^ o;
         4'h5: return ~x & ~o;
         4'h6: return x << sh;
         4'h7: return x >> sh;
         4'h8: begin wide = {{32{x[31]}}, x} >> sh; return wide[31:0]; end
         4'h9: return {31'b0, (x ^ 32'h8000_0000) < (o ^ 32'h8000_0000)};
         4'hA: return {31'b0, x < o};
         4'hB: return o;
         default: return 32'h0;
      endcase
   endfunction

   initial begin
      //           a             b             imm       ext   src   op     en    exp_y         flags   exp_imm
      vecs.push_back('{32'd25,       32'd0,        14'd5,    1'b1, 1'b1, 4'h0, 1'b1, 32'd30,       3'b001, 32'h0000_0005});
      vecs.push_back('{32'd1,        32'd0,        14'h3FFF, 1'b1, 1'b1, 4'h0, 1'b1, 32'h0,        3'b100, 32'hFFFF_FFFF});
      vecs.push_back('{32'd1,        32'd7,        14'h3FFF, 1'b0, 1'b0, 4'h0, 1'b1, 32'd8,        3'b001, 32'h0000_3FFF});
      vecs.push_back('{32'd5,        32'd5,        14'd0,    1'b0, 1'b0, 4'h1, 1'b1, 32'h0,        3'b100, 32'h0});
      vecs.push_back('{32'd3,        32'd5,        14'd0,    1'b0, 1'b0, 4'h1, 1'b1, 32'hFFFF_FFFE, 3'b010, 32'h0});
      vecs.push_back('{32'hFFFF_FFFF, 32'd1,       14'd0,    1'b0, 1'b0, 4'h9, 1'b1, 32'd1,        3'b001, 32'h0});
      vecs.push_back('{32'hFFFF_FFFF, 32'd1,       14'd0,    1'b0, 1'b0, 4'hA, 1'b1, 32'h0,        3'b100, 32'h0});
      vecs.push_back('{32'h8000_0000, 32'd33,      14'd0,    1'b0, 1'b0, 4'h7, 1'b1, 32'h4000_0000, 3'b001, 32'h0});
      vecs.push_back('{32'h8000_0000, 32'd33,      14'd0,    1'b0, 1'b0, 4'h8, 1'b1, 32'hC000_0000, 3'b010, 32'h0});
      vecs.push_back('{32'h8000_0000, 32'd33,      14'd0,    1'b0, 1'b0, 4'h6, 1'b1, 32'h0,        3'b100, 32'h0});
      vecs.push_back('{32'hF0F0_F0F0, 32'hFF00_FF00, 14'd0,  1'b0, 1'b0, 4'h2, 1'b1, 32'hF000_F000, 3'b010, 32'h0});
      vecs.push_back('{32'hF0F0_F0F0, 32'hFF00_FF00, 14'd0,  1'b0, 1'b0, 4'h3, 1'b1, 32'hFFF0_FFF0, 3'b010, 32'h0});
      vecs.push_back('{32'hF0F0_F0F0, 32'hFF00_FF00, 14'd0,  1'b0, 1'b0, 4'h4, 1'b1, 32'h0FF0_0FF0, 3'b001, 32'h0});
      vecs.push_back('{32'hF0F0_F0F0, 32'hFF00_FF00, 14'd0,  1'b0, 1'b0, 4'h5, 1'b1, 32'h000F_000F, 3'b001, 32'h0});
      vecs.push_back('{32'hDEAD_BEEF, 32'h1234_5678, 14'd0,  1'b0, 1'b0, 4'hB, 1'b1, 32'h1234_5678, 3'b001, 32'h0});
      vecs.push_back('{32'd7,        32'd9,        14'd0,    1'b0, 1'b0, 4'hC, 1'b1, 32'h0,        3'b100, 32'h0});
      vecs.push_back('{32'd7,        32'd9,        14'd0,    1'b0, 1'b0, 4'hF, 1'b1, 32'h0,        3'b100, 32'h0});
      vecs.push_back('{32'd25,       32'd5,        14'd0,    1'b0, 1'b0, 4'h0, 1'b0, 32'h0,        3'b000, 32'h0});
      vecs.push_back('{32'd0,        32'd0,        14'h1FFF, 1'b1, 1'b1, 4'hB, 1'b1, 32'h0000_1FFF, 3'b001, 32'h0000_1FFF});
      vecs.push_back('{32'd0,        32'd0,        14'h2000, 1'b1, 1'b1, 4'hB, 1'b1, 32'hFFFF_E000, 3'b010, 32'hFFFF_E000});

      // Reset: held with write_en=1 and y=25, result_q must stay 0 across edges.
      a = 32'd20; b = 32'd5; alu_control = 4'h0; src_imm = 1'b0; write_en = 1'b1;
      #1 reset = 1'b1;
      #1 check("reset_immediate", result_q, 32'h0);
      check("reset_comb_y", y, 32'd25);
      repeat (2) @(posedge clk);
      #1 check("reset_held_edges", result_q, 32'h0);
      @(negedge clk) reset = 1'b0;
      @(posedge clk);
      #1 check("reset_release_load", result_q, 32'd25);

      // Hold: write_en=0 while y changes.
      @(negedge clk) write_en = 1'b0; a = 32'd100;
      #1 check("hold_y_changed", y, 32'd105);
      repeat (2) @(posedge clk);
      #1 check("hold_result", result_q, 32'd25);

      // Mid-cycle reset clears before the next edge.
      #2 reset = 1'b1;
      #1 check("midcycle_reset", result_q, 32'h0);
      @(negedge clk) reset = 1'b0;

      // Table-driven vectors, each also loaded into result_q through the scoreboard.
      foreach (vecs[i]) begin
         @(negedge clk);
         a = vecs[i].a; b = vecs[i].b; imm_in = vecs[i].imm; ext_ctrl = vecs[i].ext;
         src_imm = vecs[i].src; alu_control = vecs[i].op; en = vecs[i].en; write_en = 1'b1;
         #1;
         check($sformatf("vec%0d_imm_out", i), imm_out, vecs[i].exp_imm);
         check($sformatf("vec%0d_y", i), y, vecs[i].exp_y);
         check($sformatf("vec%0d_flags", i), {29'b0, zero, negative, positive}, {29'b0, vecs[i].exp_f});
         sb.push_back(vecs[i].exp_y);
         @(posedge clk);
         #1 check_sb($sformatf("vec%0d_result_q", i));
      end
      last_q = vecs[vecs.size()-1].exp_y;

      // Random sweep against the reference model, with random write enables.
      for (int i = 0; i < 60; i++) begin
         logic [31:0] opb_m, y_m, imm_m;
         logic [2:0]  f_m;
         @(negedge clk);
         a = $urandom; b = $urandom; imm_in = 14'($urandom);
         ext_ctrl = 1'($urandom); src_imm = 1'($urandom);
         alu_control = 4'($urandom_range(0, 15));
         en = ($urandom_range(0, 7) != 0); write_en = 1'($urandom);
         if (i % 4 == 0) b = b & 32'h0000_001F;
         imm_m = ext_ctrl ? {{18{imm_in[13]}}, imm_in} : {18'b0, imm_in};
         opb_m = src_imm ? imm_m : b;
         y_m = model_y(a, opb_m, alu_control, en);
         f_m = en ? {y_m == 32'h0, y_m[31], !y_m[31] && (y_m != 32'h0)} : 3'b000;
         #1;
         check($sformatf("rnd%0d_imm_out", i), imm_out, imm_m);
         check($sformatf("rnd%0d_y", i), y, y_m);
         check($sformatf("rnd%0d_flags", i), {29'b0, zero, negative, positive}, {29'b0, f_m});
         if (write_en) last_q = y_m;
         sb.push_back(last_q);
         @(posedge clk);
         #1 check_sb($sformatf("rnd%0d_result_q", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
